// File: rtl/psum_accum_pkg.sv
// Shared sizes and types for the psum accumulation path.
//   BIGGER_DATA_SIZE : PE psum width (signed)
//   DATA_SIZE        : activation / output width (signed)
//   ACC_SIZE         : accumulator width (signed)
package psum_accum_pkg;
  localparam int BIGGER_DATA_SIZE = 10;
  localparam int DATA_SIZE        = 8;
  localparam int OUT_SIZE         = DATA_SIZE;
  localparam int ACC_SIZE         = 14;

  typedef logic signed [BIGGER_DATA_SIZE-1:0] psum_t;
  typedef logic signed [DATA_SIZE-1:0]        act_t;
  typedef logic signed [ACC_SIZE-1:0]         acc_t;

  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} accum_state_t;
endpackage

// File: rtl/psum_accum_if.sv
// Bus between a psum producer/ofmap consumer and psum_accum.
//   psum_i/psum_valid_i : PE partial sum, no backpressure
//   clear_i             : abort the partial group, clear overflow
//   out_*               : result FIFO head with valid/ready
//   busy_o/overflow_o/fifo_count_o : status
// master = environment side, slave = psum_accum side.
interface psum_accum_if import psum_accum_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  psum_t            psum_i;
  logic             psum_valid_i;
  logic             clear_i;
  act_t             out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;
  logic             overflow_o;
  logic [CNT_W-1:0] fifo_count_o;

  modport master (
    output psum_i, psum_valid_i, clear_i, out_ready_i,
    input  out_data_o, out_valid_o, busy_o, overflow_o, fifo_count_o
  );
  modport slave (
    input  psum_i, psum_valid_i, clear_i, out_ready_i,
    output out_data_o, out_valid_o, busy_o, overflow_o, fifo_count_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, DEPTH a power of two.
//   push_i/din_i : write (ignored when full unless popping the same cycle)
//   pop_i        : read (ignored when empty; no fall-through)
//   dout_o       : head entry, straight from the storage registers
//   full_o/empty_o/count_o : occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // a pop frees the slot the push needs, so full+push+pop both succeed
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/psum_accum.sv
// Sums NUM_PSUMS consecutive valid psums, applies optional ReLU, saturates
// to DATA_SIZE signed and queues the result for the ofmap write path.
//   clk/rst : clock, async active-high reset
//   bus     : psum input, clear, result FIFO head (valid/ready) and status
module psum_accum import psum_accum_pkg::*; #(
  parameter int NUM_PSUMS  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int RELU_EN    = 1
) (
  input  logic         clk,
  input  logic         rst,
  psum_accum_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_PSUMS + 1);
  localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_SIZE - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (DATA_SIZE - 1)));

  accum_state_t     state_q;
  acc_t             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             overflow_q;

  acc_t             psum_ext, relu_v;
  act_t             result_d;
  logic             push, pop, full, empty;
  logic [DATA_SIZE-1:0] head;

  assign psum_ext = acc_t'(bus.psum_i);

  always_comb begin
    relu_v = acc_q;
    if (RELU_EN != 0 && acc_q < 0) relu_v = '0;
    if (relu_v > SAT_MAX)      result_d = act_t'(SAT_MAX);
    else if (relu_v < SAT_MIN) result_d = act_t'(SAT_MIN);
    else                       result_d = relu_v[DATA_SIZE-1:0];
  end

  // clear_i kills the write of a pending PUSH
  assign push = (state_q == PUSH) && !bus.clear_i;
  assign pop  = bus.out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (bus.psum_valid_i) begin
            acc_q <= acc_q + psum_ext;
            cnt_q <= cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == CNT_W'(NUM_PSUMS)) state_q <= PUSH;
          end
        end
        // IDLE and PUSH both start a new group on a valid psum
        IDLE, PUSH: begin
          if (bus.psum_valid_i) begin
            acc_q   <= psum_ext;
            cnt_q   <= CNT_W'(1);
            state_q <= (NUM_PSUMS == 1) ? PUSH : ACCUM;
          end else begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (result_d),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (bus.fifo_count_o)
  );

  assign bus.out_data_o  = act_t'(head);
  assign bus.out_valid_o = !empty;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: one instance with ReLU, one without, fed the same
// stimulus. Expected results go into per-instance queues when the last psum
// of a group is driven and are checked when the consumer pops them.
module tb_psum_accum;
  import psum_accum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_accum_if bus_r ();
  psum_accum_if bus_n ();

  psum_accum #(.NUM_PSUMS(3), .FIFO_DEPTH(4), .RELU_EN(1)) u_dut_r (
    .clk(clk), .rst(rst), .bus(bus_r.slave));
  psum_accum #(.NUM_PSUMS(3), .FIFO_DEPTH(4), .RELU_EN(0)) u_dut_n (
    .clk(clk), .rst(rst), .bus(bus_n.slave));

  int checks = 0;
  int failures = 0;
  int q_r[$];
  int q_n[$];

  typedef struct {
    int a, b, c;
    int exp_r, exp_n;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input int p, input logic clr);
    bus_r.psum_valid_i = v; bus_n.psum_valid_i = v;
    bus_r.psum_i = psum_t'(p); bus_n.psum_i = psum_t'(p);
    bus_r.clear_i = clr; bus_n.clear_i = clr;
  endtask

  task automatic send(input int p);
    set_in(1'b1, p, 1'b0);
    tick();
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ready(input logic r);
    bus_r.out_ready_i = r; bus_n.out_ready_i = r;
  endtask

  task automatic exp_push(input int er, input int en);
    q_r.push_back(er);
    q_n.push_back(en);
  endtask

  task automatic drain(input string name);
    set_ready(1'b1);
    set_in(1'b0, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (q_r.size() == 0 && q_n.size() == 0 && !bus_r.out_valid_o && !bus_n.out_valid_o) break;
      tick();
    end
    chk({name, "_q_r_empty"}, q_r.size(), 0);
    chk({name, "_q_n_empty"}, q_n.size(), 0);
    chk({name, "_valid_r_low"}, int'(bus_r.out_valid_o), 0);
  endtask

  // consumer-side scoreboard: a pop happens at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_r.out_valid_o && bus_r.out_ready_i) begin
        if (q_r.size() == 0) chk("pop_r_unexpected", int'(bus_r.out_data_o), 9999);
        else chk("pop_r_data", int'(bus_r.out_data_o), q_r.pop_front());
      end
      if (bus_n.out_valid_o && bus_n.out_ready_i) begin
        if (q_n.size() == 0) chk("pop_n_unexpected", int'(bus_n.out_data_o), 9999);
        else chk("pop_n_data", int'(bus_n.out_data_o), q_n.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{a: 10,   b: 20,   c: 30,   exp_r: 60,  exp_n: 60};
    vecs[1]  = '{a: 300,  b: 300,  c: 300,  exp_r: 127, exp_n: 127};
    vecs[2]  = '{a: -5,   b: -5,   c: -5,   exp_r: 0,   exp_n: -15};
    vecs[3]  = '{a: -200, b: -200, c: 100,  exp_r: 0,   exp_n: -128};
    vecs[4]  = '{a: -512, b: -512, c: -512, exp_r: 0,   exp_n: -128};
    vecs[5]  = '{a: 127,  b: 0,    c: 0,    exp_r: 127, exp_n: 127};
    vecs[6]  = '{a: 128,  b: 0,    c: 0,    exp_r: 127, exp_n: 127};
    vecs[7]  = '{a: -128, b: 0,    c: 0,    exp_r: 0,   exp_n: -128};
    vecs[8]  = '{a: -129, b: 0,    c: 0,    exp_r: 0,   exp_n: -128};
    vecs[9]  = '{a: 50,   b: -60,  c: 5,    exp_r: 0,   exp_n: -5};
    vecs[10] = '{a: 511,  b: 511,  c: 511,  exp_r: 127, exp_n: 127};
    vecs[11] = '{a: -100, b: -27,  c: -1,   exp_r: 0,   exp_n: -128};

    set_in(1'b0, 0, 1'b0);
    set_ready(1'b1);

    // reset values
    #3;
    chk("rst_valid", int'(bus_r.out_valid_o), 0);
    chk("rst_data", int'(bus_r.out_data_o), 0);
    chk("rst_busy", int'(bus_r.busy_o), 0);
    chk("rst_ovf", int'(bus_r.overflow_o), 0);
    chk("rst_count", int'(bus_r.fifo_count_o), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // basic group and 2-cycle latency
    send(10); send(20); send(30);
    exp_push(60, 60);
    set_ready(1'b0);
    chk("basic_busy_push", int'(bus_r.busy_o), 1);
    chk("basic_valid_early", int'(bus_r.out_valid_o), 0);
    idle(1);
    chk("basic_valid", int'(bus_r.out_valid_o), 1);
    chk("basic_count", int'(bus_r.fifo_count_o), 1);
    chk("basic_data", int'(bus_r.out_data_o), 60);
    chk("basic_busy_idle", int'(bus_r.busy_o), 0);
    drain("basic");

    // table: back-to-back groups at one psum per cycle
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a); send(vecs[i].b); send(vecs[i].c);
      exp_push(vecs[i].exp_r, vecs[i].exp_n);
    end
    idle(1);
    drain("table");

    // gaps between psums
    send(1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("gap_busy", int'(bus_r.busy_o), 1);
    end
    send(2);
    idle(1);
    chk("gap_busy2", int'(bus_r.busy_o), 1);
    send(3);
    exp_push(6, 6);
    chk("gap_busy_push", int'(bus_r.busy_o), 1);
    idle(1);
    chk("gap_busy_done", int'(bus_r.busy_o), 0);
    drain("gap");

    // backpressure: fifth result dropped
    set_ready(1'b0);
    for (int g = 0; g < 5; g++) begin
      send(1); send(1); send(1);
      if (g < 4) exp_push(3, 3);
    end
    chk("ovf_before_drop", int'(bus_r.overflow_o), 0);
    idle(1);
    chk("ovf_count", int'(bus_r.fifo_count_o), 4);
    chk("ovf_count_n", int'(bus_n.fifo_count_o), 4);
    chk("ovf_flag", int'(bus_r.overflow_o), 1);
    chk("ovf_hold_data", int'(bus_r.out_data_o), 3);
    drain("ovf");
    chk("ovf_sticky", int'(bus_r.overflow_o), 1);
    set_in(1'b0, 0, 1'b1);
    tick();
    set_in(1'b0, 0, 1'b0);
    chk("ovf_cleared", int'(bus_r.overflow_o), 0);

    // full FIFO: push coincides with a pop
    set_ready(1'b0);
    for (int g = 0; g < 5; g++) begin
      send(g + 1); send(0); send(0);
      exp_push(g + 1, g + 1);
    end
    chk("fullpp_count_pre", int'(bus_r.fifo_count_o), 4);
    set_ready(1'b1);
    idle(1);
    set_ready(1'b0);
    chk("fullpp_count", int'(bus_r.fifo_count_o), 4);
    chk("fullpp_ovf", int'(bus_r.overflow_o), 0);
    chk("fullpp_head", int'(bus_r.out_data_o), 2);
    drain("fullpp");

    // clear drops the partial group
    send(7); send(7);
    set_in(1'b0, 0, 1'b1);
    tick();
    set_in(1'b0, 0, 1'b0);
    chk("clr_busy", int'(bus_r.busy_o), 0);
    send(1); send(2); send(3);
    exp_push(6, 6);
    idle(1);
    drain("clr");

    // clear during PUSH discards the result
    send(1); send(1); send(1);
    set_in(1'b0, 0, 1'b1);
    tick();
    set_in(1'b0, 0, 1'b0);
    chk("clrpush_count", int'(bus_r.fifo_count_o), 0);
    chk("clrpush_busy", int'(bus_r.busy_o), 0);

    // async reset mid-FIFO and mid-group
    set_ready(1'b0);
    send(1); send(1); send(1);
    idle(1);
    chk("rst2_count_pre", int'(bus_r.fifo_count_o), 1);
    send(5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst2_valid", int'(bus_r.out_valid_o), 0);
    chk("rst2_data", int'(bus_r.out_data_o), 0);
    chk("rst2_busy", int'(bus_r.busy_o), 0);
    chk("rst2_count", int'(bus_r.fifo_count_o), 0);
    chk("rst2_count_n", int'(bus_n.fifo_count_o), 0);
    q_r.delete();
    q_n.delete();
    idle(1);
    rst = 1'b0;
    set_ready(1'b1);
    send(10); send(20); send(30);
    exp_push(60, 60);
    idle(1);
    drain("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
